vga_pattern_gen: RTL and testbench
==================================

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL expose parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL expose parameter H_FRONT, default 21, front-porch pixels.
REQ-003 SHALL expose parameter H_SYNC, default 95, hsync pixels.
REQ-004 SHALL expose parameter H_BACK, default 60, back-porch pixels; line total = sum of the four H parameters (816).
REQ-005 SHALL expose parameters V_ACTIVE 480, V_FRONT 13, V_SYNC 2, V_BACK 30, all in lines; frame total = sum (525).
REQ-006 SHALL expose parameter COLOR_W, default 10, bits per colour channel.
REQ-007 SHALL expose parameter SYNC_POL, default 0; 0 = active-low syncs, 1 = active-high.
REQ-008 Ports (already decided): one clock; reset asynchronous, active-low.
REQ-009 CLOCK_50  in  1  pixel clock, all logic on rising edge.
REQ-010 RESET_N  in  1  asynchronous active-low reset.
REQ-011 MODE  in  2  pattern select: 0 quadrant, 1 colour bars, 2 grey ramp, 3 solid.
REQ-012 SOLID_RGB  in  3*COLOR_W  {R,G,B} colour for mode 3.
REQ-013 VGA_R, VGA_G, VGA_B  out  COLOR_W each  pixel colour.
REQ-014 VGA_CLK  out  1  equals CLOCK_50.
REQ-015 VGA_BLANK  out  1  active-low blank: 1 in active area.
REQ-016 VGA_HS, VGA_VS  out  1 each  syncs, polarity per SYNC_POL.
REQ-017 FRAME_START  out  1  one-cycle pulse at first pixel of each frame.

Function
REQ-018 h counter SHALL count 0..H_total-1 and wrap to 0; v counter SHALL increment exactly when h wraps and wrap to 0 after V_total-1.
REQ-019 hsync SHALL be active for h in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] (661..755 default); vsync likewise for v in [V_ACTIVE+V_FRONT, +V_SYNC-1] (493..494).
REQ-020 Active area SHALL be h<H_ACTIVE and v<V_ACTIVE; outside it R/G/B SHALL be 0.
REQ-021 All outputs except VGA_CLK SHALL be registered; colour, BLANK, HS, VS and FRAME_START for counter position (h,v) SHALL appear together one cycle after the counters hold (h,v).
REQ-022 MODE and SOLID_RGB SHALL be sampled into internal registers only when h=0 and v=0; mid-frame changes take effect next frame.
REQ-023 Mode 0: select on {x[6],y[6]}: 00 R=G=0, B={y[5:0],zeros}; 01 R full-scale; 10 G full-scale; 11 all full-scale.
REQ-024 Mode 1: eight equal bars of width H_ACTIVE/8 (integer division); bar index k (0..7) drives R=k[2], G=k[1], B=k[0] each replicated to full scale; bar index from a width counter, no divider.
REQ-025 Mode 2: R=G=B = x truncated/zero-extended to COLOR_W bits.
REQ-026 Mode 3: R,G,B = SOLID_RGB slices, MSB slice = R.
REQ-027 FRAME_START SHALL be 1 for exactly one cycle per frame, aligned with pixel (0,0) output.

Reset
REQ-028 On RESET_N low, asynchronously: counters 0, mode register 0, solid register 0, R/G/B 0, BLANK 0, HS/VS inactive level, FRAME_START 0.
REQ-029 After RESET_N rises, first output cycle SHALL be pixel (0,0) with FRAME_START=1; reset mid-frame SHALL abort the frame without glitching syncs active.

Configuration
REQ-030 Macro VGA_PATTERN_SCROLL_EN: when defined, an 8-bit frame counter (reset 0, +1 per frame, wraps) SHALL be added to x before pattern lookup in modes 0-2, scrolling one pixel per frame; when undefined, no frame counter exists and x is unmodified.

Verification
REQ-031 Reset release, defaults -> FRAME_START at output cycle 1, HS low for output cycles with h=661..755, 816 cycles per line, 428400 cycles per frame.
REQ-032 MODE=1, defaults -> pixels x=0..79 black, x=80..159 B=0x3FF only, x=560..639 white, x=640 black with BLANK=0.
REQ-033 MODE changed 0->3 at (h=100,v=10) with SOLID_RGB={0x200,0x100,0x080} -> remainder of frame unchanged quadrant pattern; next frame all active pixels 0x200/0x100/0x080.
REQ-034 SYNC_POL=1, H_ACTIVE=32, H_FRONT=2, H_SYNC=4, H_BACK=2, V_ACTIVE=4, V_FRONT=1, V_SYNC=1, V_BACK=1 -> HS high for h=34..37 of 40-cycle line, VS high for line 5 of 7.
REQ-035 RESET_N pulsed low at (h=300,v=200) -> outputs immediately at reset values; after release, line/frame timing restarts from (0,0).
REQ-036 With VGA_PATTERN_SCROLL_EN, MODE=2 -> pixel x=0 value equals frame index (0,1,2,...) on successive frames, wrapping after 255.

Source files
------------

// File: rtl/vga_pattern_gen_if.sv
// Pattern-select inputs and VGA output bus of the pattern generator.
// The generator takes the slave side; whoever drives MODE/SOLID_RGB and watches the video takes the master side.
interface vga_pattern_gen_if #(
  parameter int COLOR_W = 10
);
  logic [1:0]           MODE;
  logic [3*COLOR_W-1:0] SOLID_RGB;
  logic [COLOR_W-1:0]   VGA_R;
  logic [COLOR_W-1:0]   VGA_G;
  logic [COLOR_W-1:0]   VGA_B;
  logic                 VGA_CLK;
  logic                 VGA_BLANK;
  logic                 VGA_HS;
  logic                 VGA_VS;
  logic                 FRAME_START;

  modport master (
    output MODE, SOLID_RGB,
    input  VGA_R, VGA_G, VGA_B, VGA_CLK, VGA_BLANK, VGA_HS, VGA_VS, FRAME_START
  );

  modport slave (
    input  MODE, SOLID_RGB,
    output VGA_R, VGA_G, VGA_B, VGA_CLK, VGA_BLANK, VGA_HS, VGA_VS, FRAME_START
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA timing generator with four test patterns (quadrant, bars, grey ramp, solid) and registered outputs.
// Optional macro VGA_PATTERN_SCROLL_EN adds an 8-bit frame counter that scrolls modes 0-2 one pixel per frame.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 21,
  parameter int H_SYNC   = 95,
  parameter int H_BACK   = 60,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 13,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 30,
  parameter int COLOR_W  = 10,
  parameter int SYNC_POL = 0
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  vga_pattern_gen_if.slave vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
  localparam logic          SYNC_ON  = (SYNC_POL != 0);
  localparam logic          SYNC_OFF = ~SYNC_ON;
  localparam logic [COLOR_W-1:0] FULL = '1;

  logic [HW-1:0]        hCount_q, hCount_d;
  logic [VW-1:0]        vCount_q, vCount_d;
  logic [1:0]           mode_q, mode_d;
  logic [3*COLOR_W-1:0] solid_q, solid_d;
  logic [BW-1:0]        barCnt_q, barCnt_d, barStartCnt;
  logic [2:0]           barIdx_q, barIdx_d, barStartIdx;
  logic [COLOR_W-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic                 blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;
  logic                 frameStart_q, frameStart_d;
  logic                 hEnd, vEnd, frameOrigin, active, xBit6, yBit6;
  logic [HW-1:0]        xPos;

  always_comb begin
    hEnd        = (hCount_q == H_LAST);
    vEnd        = (vCount_q == V_LAST);
    frameOrigin = (hCount_q == '0) && (vCount_q == '0);
    hCount_d    = hEnd ? '0 : hCount_q + HW'(1);
    vCount_d    = vCount_q;
    if (hEnd) begin
      vCount_d = vEnd ? '0 : vCount_q + VW'(1);
    end
  end

`ifdef VGA_PATTERN_SCROLL_EN
  // The bar counter preload follows the scroll offset so bars need no divider even when shifted.
  logic [7:0]    frame_q, frame_d;
  logic [BW-1:0] lineCnt_q, lineCnt_d;
  logic [2:0]    lineIdx_q, lineIdx_d;

  always_comb begin
    frame_d   = frame_q;
    lineCnt_d = lineCnt_q;
    lineIdx_d = lineIdx_q;
    if (hEnd && vEnd) begin
      frame_d = frame_q + 8'd1;
      if (frame_q == 8'hFF) begin
        lineCnt_d = '0;
        lineIdx_d = '0;
      end else if (lineCnt_q == BAR_LAST) begin
        lineCnt_d = '0;
        lineIdx_d = lineIdx_q + 3'd1;
      end else begin
        lineCnt_d = lineCnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_q   <= '0;
      lineCnt_q <= '0;
      lineIdx_q <= '0;
    end else begin
      frame_q   <= frame_d;
      lineCnt_q <= lineCnt_d;
      lineIdx_q <= lineIdx_d;
    end
  end

  assign xPos        = hCount_q + HW'(frame_q);
  assign barStartCnt = lineCnt_d;
  assign barStartIdx = lineIdx_d;
`else
  assign xPos        = hCount_q;
  assign barStartCnt = '0;
  assign barStartIdx = '0;
`endif

  always_comb begin
    if (hEnd) begin
      barCnt_d = barStartCnt;
      barIdx_d = barStartIdx;
    end else if (barCnt_q == BAR_LAST) begin
      barCnt_d = '0;
      barIdx_d = barIdx_q + 3'd1;
    end else begin
      barCnt_d = barCnt_q + BW'(1);
      barIdx_d = barIdx_q;
    end
  end

  // The value taken at (0,0) already applies to pixel (0,0), so a whole frame shares one mode.
  always_comb begin
    mode_d  = frameOrigin ? vga.MODE : mode_q;
    solid_d = frameOrigin ? vga.SOLID_RGB : solid_q;
  end

  always_comb begin
    active  = (hCount_q < H_ACT) && (vCount_q < V_ACT);
    xBit6   = ((xPos & HW'(64)) != '0);
    yBit6   = ((vCount_q & VW'(64)) != '0);
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (active) begin
      case (mode_d)
        2'd0: begin
          case ({xBit6, yBit6})
            2'b00:   blue_d  = COLOR_W'({6'(vCount_q), COLOR_W'(0)} >> 6);
            2'b01:   red_d   = FULL;
            2'b10:   green_d = FULL;
            default: begin
              red_d   = FULL;
              green_d = FULL;
              blue_d  = FULL;
            end
          endcase
        end
        2'd1: begin
          red_d   = {COLOR_W{barIdx_q[2]}};
          green_d = {COLOR_W{barIdx_q[1]}};
          blue_d  = {COLOR_W{barIdx_q[0]}};
        end
        2'd2: begin
          red_d   = COLOR_W'(xPos);
          green_d = COLOR_W'(xPos);
          blue_d  = COLOR_W'(xPos);
        end
        default: begin
          red_d   = solid_d[3*COLOR_W-1:2*COLOR_W];
          green_d = solid_d[2*COLOR_W-1:COLOR_W];
          blue_d  = solid_d[COLOR_W-1:0];
        end
      endcase
    end
    blank_d      = active;
    hs_d         = (hCount_q >= HS_FIRST && hCount_q <= HS_LAST) ? SYNC_ON : SYNC_OFF;
    vs_d         = (vCount_q >= VS_FIRST && vCount_q <= VS_LAST) ? SYNC_ON : SYNC_OFF;
    frameStart_d = frameOrigin;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      hCount_q     <= '0;
      vCount_q     <= '0;
      mode_q       <= '0;
      solid_q      <= '0;
      barCnt_q     <= '0;
      barIdx_q     <= '0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      blank_q      <= 1'b0;
      hs_q         <= SYNC_OFF;
      vs_q         <= SYNC_OFF;
      frameStart_q <= 1'b0;
    end else begin
      hCount_q     <= hCount_d;
      vCount_q     <= vCount_d;
      mode_q       <= mode_d;
      solid_q      <= solid_d;
      barCnt_q     <= barCnt_d;
      barIdx_q     <= barIdx_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      blank_q      <= blank_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign vga.VGA_R       = red_q;
  assign vga.VGA_G       = green_q;
  assign vga.VGA_B       = blue_q;
  assign vga.VGA_BLANK   = blank_q;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.FRAME_START = frameStart_q;
  assign vga.VGA_CLK     = CLOCK_50;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: default 640x480 timing, a tiny active-high-sync geometry and a 128x128 geometry.
`timescale 1ns/1ps
module tb_vga_pattern_gen;

  localparam int CW   = 10;
  localparam int A_HT = 816;
  localparam int B_HT = 40;
  localparam int B_FT = 280;
  localparam int C_HT = 136;
  localparam int C_FT = 136 * 131;

  logic clk = 1'b0;
  logic rstA_n = 1'b0;
  logic rstB_n = 1'b0;
  logic rstC_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   pixA = -1;
  int   pixB = -1;
  int   pixC = -1;

  vga_pattern_gen_if #(.COLOR_W(CW)) ifA ();
  vga_pattern_gen_if #(.COLOR_W(CW)) ifB ();
  vga_pattern_gen_if #(.COLOR_W(CW)) ifC ();

  vga_pattern_gen dutA (.CLOCK_50(clk), .RESET_N(rstA_n), .vga(ifA));

  vga_pattern_gen #(
    .H_ACTIVE(32), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .COLOR_W(CW), .SYNC_POL(1)
  ) dutB (.CLOCK_50(clk), .RESET_N(rstB_n), .vga(ifB));

  vga_pattern_gen #(
    .H_ACTIVE(128), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_ACTIVE(128), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .COLOR_W(CW), .SYNC_POL(0)
  ) dutC (.CLOCK_50(clk), .RESET_N(rstC_n), .vga(ifC));

  always #5 clk = ~clk;

  // Each pixN tracks which pixel index the sampled outputs currently show (-1 right after reset release).
  task automatic stepA(input int target);
    while (pixA < target) begin @(negedge clk); pixA++; end
  endtask

  task automatic stepB(input int target);
    while (pixB < target) begin @(negedge clk); pixB++; end
  endtask

  task automatic stepC(input int target);
    while (pixC < target) begin @(negedge clk); pixC++; end
  endtask

  task automatic resetA();
    @(negedge clk); rstA_n = 1'b0; @(negedge clk); rstA_n = 1'b1; pixA = -1;
  endtask

  task automatic resetB();
    @(negedge clk); rstB_n = 1'b0; @(negedge clk); rstB_n = 1'b1; pixB = -1;
  endtask

  task automatic resetC();
    @(negedge clk); rstC_n = 1'b0; @(negedge clk); rstC_n = 1'b1; pixC = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstA_n = 1'b1; rstB_n = 1'b1; rstC_n = 1'b1;
    pixA = -1;
    stepA(699);
    checks++;
    if (ifA.VGA_HS !== 1'b0) begin errors++; $display("[TB] FAIL pre_reset_hs: got %b expected 0", ifA.VGA_HS); end
    #2;
    rstA_n = 1'b0; rstB_n = 1'b0; rstC_n = 1'b0;
    #1;
    checks++;
    if ({ifA.VGA_R, ifA.VGA_G, ifA.VGA_B} !== 30'h0) begin errors++; $display("[TB] FAIL reset_rgb: got %h expected 0", {ifA.VGA_R, ifA.VGA_G, ifA.VGA_B}); end
    checks++;
    if (ifA.VGA_BLANK !== 1'b0) begin errors++; $display("[TB] FAIL reset_blank: got %b expected 0", ifA.VGA_BLANK); end
    checks++;
    if (ifA.VGA_HS !== 1'b1 || ifA.VGA_VS !== 1'b1) begin errors++; $display("[TB] FAIL reset_sync_low_pol: got hs=%b vs=%b expected 1/1", ifA.VGA_HS, ifA.VGA_VS); end
    checks++;
    if (ifB.VGA_HS !== 1'b0 || ifB.VGA_VS !== 1'b0) begin errors++; $display("[TB] FAIL reset_sync_high_pol: got hs=%b vs=%b expected 0/0", ifB.VGA_HS, ifB.VGA_VS); end
    checks++;
    if (ifA.VGA_CLK !== 1'b0) begin errors++; $display("[TB] FAIL vga_clk_low: got %b expected 0", ifA.VGA_CLK); end
    #3;
    checks++;
    if (ifA.VGA_CLK !== 1'b1) begin errors++; $display("[TB] FAIL vga_clk_high: got %b expected 1", ifA.VGA_CLK); end
    @(negedge clk);
    checks++;
    if (ifA.FRAME_START !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_start: got %b expected 0", ifA.FRAME_START); end
  endtask

  task automatic test_line_timing();
    int fsCount = 0;
    int vsLow = 0;
    int lowCount = 0;
    int firstLow = -1;
    int lastLow = -1;
    int nFall = 0;
    int falls[2] = '{-1, -1};
    logic prevHs;
    ifA.MODE = 2'd0;
    ifA.SOLID_RGB = '0;
    resetA();
    stepA(0);
    checks++;
    if (ifA.FRAME_START !== 1'b1) begin errors++; $display("[TB] FAIL first_frame_start: got %b expected 1", ifA.FRAME_START); end
    checks++;
    if (ifA.VGA_BLANK !== 1'b1) begin errors++; $display("[TB] FAIL first_blank: got %b expected 1", ifA.VGA_BLANK); end
    prevHs = ifA.VGA_HS;
    for (int p = 1; p < 2 * A_HT; p++) begin
      stepA(p);
      if (ifA.FRAME_START === 1'b1) fsCount++;
      if (ifA.VGA_VS !== 1'b1) vsLow++;
      if (p < A_HT && ifA.VGA_HS === 1'b0) begin
        lowCount++;
        if (firstLow < 0) firstLow = p;
        lastLow = p;
      end
      if (prevHs === 1'b1 && ifA.VGA_HS === 1'b0 && nFall < 2) begin falls[nFall] = p; nFall++; end
      prevHs = ifA.VGA_HS;
      if (p == 639) begin
        checks++;
        if (ifA.VGA_BLANK !== 1'b1) begin errors++; $display("[TB] FAIL blank_x639: got %b expected 1", ifA.VGA_BLANK); end
      end
      if (p == 640) begin
        checks++;
        if (ifA.VGA_BLANK !== 1'b0) begin errors++; $display("[TB] FAIL blank_x640: got %b expected 0", ifA.VGA_BLANK); end
      end
    end
    checks++;
    if (fsCount !== 0) begin errors++; $display("[TB] FAIL extra_frame_start: got %0d expected 0", fsCount); end
    checks++;
    if (vsLow !== 0) begin errors++; $display("[TB] FAIL vs_in_lines_0_1: got %0d active cycles expected 0", vsLow); end
    checks++;
    if (firstLow !== 661 || lastLow !== 755) begin errors++; $display("[TB] FAIL hs_window: got %0d..%0d expected 661..755", firstLow, lastLow); end
    checks++;
    if (lowCount !== 95) begin errors++; $display("[TB] FAIL hs_width: got %0d expected 95", lowCount); end
    checks++;
    if (nFall !== 2 || falls[1] - falls[0] !== A_HT) begin errors++; $display("[TB] FAIL line_period: got %0d expected 816", falls[1] - falls[0]); end
  endtask

  task automatic test_color_bars();
    int bad = 0;
    int k;
    logic [29:0] expRgb;
    ifA.MODE = 2'd1;
    resetA();
    for (int p = 0; p <= 640; p++) begin
      stepA(p);
      k = p / 80;
      expRgb = (p < 640) ? {{CW{k[2]}}, {CW{k[1]}}, {CW{k[0]}}} : 30'h0;
      if ({ifA.VGA_R, ifA.VGA_G, ifA.VGA_B} !== expRgb) bad++;
      if (p == 0) begin
        checks++;
        if ({ifA.VGA_R, ifA.VGA_G, ifA.VGA_B} !== 30'h0) begin errors++; $display("[TB] FAIL bar_x0: got %h expected 0", {ifA.VGA_R, ifA.VGA_G, ifA.VGA_B}); end
      end
      if (p == 80) begin
        checks++;
        if ({ifA.VGA_R, ifA.VGA_G, ifA.VGA_B} !== {10'h0, 10'h0, 10'h3FF}) begin errors++; $display("[TB] FAIL bar_x80: got %h expected blue", {ifA.VGA_R, ifA.VGA_G, ifA.VGA_B}); end
      end
      if (p == 560) begin
        checks++;
        if ({ifA.VGA_R, ifA.VGA_G, ifA.VGA_B} !== {10'h3FF, 10'h3FF, 10'h3FF}) begin errors++; $display("[TB] FAIL bar_x560: got %h expected white", {ifA.VGA_R, ifA.VGA_G, ifA.VGA_B}); end
      end
      if (p == 640) begin
        checks++;
        if ({ifA.VGA_R, ifA.VGA_G, ifA.VGA_B} !== 30'h0 || ifA.VGA_BLANK !== 1'b0) begin errors++; $display("[TB] FAIL bar_x640: got %h blank=%b expected 0 blank=0", {ifA.VGA_R, ifA.VGA_G, ifA.VGA_B}, ifA.VGA_BLANK); end
      end
    end
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL bar_line: got %0d wrong pixels expected 0", bad); end
  endtask

  task automatic test_reset_midframe();
    stepA(2 * A_HT + 300);
    checks++;
    if ({ifA.VGA_R, ifA.VGA_G, ifA.VGA_B} !== {10'h0, 10'h3FF, 10'h3FF}) begin errors++; $display("[TB] FAIL bar_x300_y2: got %h expected cyan", {ifA.VGA_R, ifA.VGA_G, ifA.VGA_B}); end
    #2;
    rstA_n = 1'b0;
    #1;
    checks++;
    if ({ifA.VGA_R, ifA.VGA_G, ifA.VGA_B} !== 30'h0 || ifA.VGA_BLANK !== 1'b0 || ifA.VGA_HS !== 1'b1 || ifA.VGA_VS !== 1'b1 || ifA.FRAME_START !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midframe_reset: got rgb=%h blank=%b hs=%b vs=%b fs=%b expected 0/0/1/1/0", {ifA.VGA_R, ifA.VGA_G, ifA.VGA_B}, ifA.VGA_BLANK, ifA.VGA_HS, ifA.VGA_VS, ifA.FRAME_START);
    end
    @(negedge clk); @(negedge clk);
    rstA_n = 1'b1;
    pixA = -1;
    stepA(0);
    checks++;
    if (ifA.FRAME_START !== 1'b1 || ifA.VGA_BLANK !== 1'b1) begin errors++; $display("[TB] FAIL restart_origin: got fs=%b blank=%b expected 1/1", ifA.FRAME_START, ifA.VGA_BLANK); end
    stepA(660);
    checks++;
    if (ifA.VGA_HS !== 1'b1) begin errors++; $display("[TB] FAIL restart_hs_660: got %b expected 1", ifA.VGA_HS); end
    stepA(661);
    checks++;
    if (ifA.VGA_HS !== 1'b0) begin errors++; $display("[TB] FAIL restart_hs_661: got %b expected 0", ifA.VGA_HS); end
  endtask

  task automatic test_sync_polarity();
    int fsCount = 0;
    int hsCount = 0;
    int hsFirst = -1;
    int hsLast = -1;
    int vsCount = 0;
    int vsWrong = 0;
    ifB.MODE = 2'd0;
    ifB.SOLID_RGB = '0;
    resetB();
    for (int p = 0; p < B_FT; p++) begin
      stepB(p);
      if (ifB.FRAME_START === 1'b1) fsCount++;
      if (p < B_HT && ifB.VGA_HS === 1'b1) begin
        hsCount++;
        if (hsFirst < 0) hsFirst = p;
        hsLast = p;
      end
      if (ifB.VGA_VS === 1'b1) begin
        vsCount++;
        if (p / B_HT != 5) vsWrong++;
      end
    end
    checks++;
    if (hsFirst !== 34 || hsLast !== 37 || hsCount !== 4) begin errors++; $display("[TB] FAIL small_hs: got %0d..%0d (%0d) expected 34..37 (4)", hsFirst, hsLast, hsCount); end
    checks++;
    if (vsCount !== 40 || vsWrong !== 0) begin errors++; $display("[TB] FAIL small_vs: got %0d cycles, %0d off line 5 expected 40, 0", vsCount, vsWrong); end
    checks++;
    if (fsCount !== 1) begin errors++; $display("[TB] FAIL small_fs_count: got %0d expected 1", fsCount); end
    stepB(B_FT);
    checks++;
    if (ifB.FRAME_START !== 1'b1) begin errors++; $display("[TB] FAIL small_frame_period: got %b expected 1", ifB.FRAME_START); end
  endtask

  task automatic test_grey_ramp();
    ifB.MODE = 2'd2;
    resetB();
    stepB(5);
    checks++;
    if ({ifB.VGA_R, ifB.VGA_G, ifB.VGA_B} !== {10'd5, 10'd5, 10'd5}) begin errors++; $display("[TB] FAIL grey_x5: got %h expected 5/5/5", {ifB.VGA_R, ifB.VGA_G, ifB.VGA_B}); end
    stepB(31);
    checks++;
    if ({ifB.VGA_R, ifB.VGA_G, ifB.VGA_B} !== {10'd31, 10'd31, 10'd31}) begin errors++; $display("[TB] FAIL grey_x31: got %h expected 31/31/31", {ifB.VGA_R, ifB.VGA_G, ifB.VGA_B}); end
    stepB(32);
    checks++;
    if ({ifB.VGA_R, ifB.VGA_G, ifB.VGA_B} !== 30'h0) begin errors++; $display("[TB] FAIL grey_x32: got %h expected 0", {ifB.VGA_R, ifB.VGA_G, ifB.VGA_B}); end
    stepB(B_HT + 17);
    checks++;
    if ({ifB.VGA_R, ifB.VGA_G, ifB.VGA_B} !== {10'd17, 10'd17, 10'd17}) begin errors++; $display("[TB] FAIL grey_x17_y1: got %h expected 17/17/17", {ifB.VGA_R, ifB.VGA_G, ifB.VGA_B}); end
  endtask

`ifdef VGA_PATTERN_SCROLL_EN
  task automatic test_scroll();
    ifB.MODE = 2'd2;
    resetB();
    for (int f = 0; f < 4; f++) begin
      stepB(f * B_FT);
      checks++;
      if (ifB.VGA_R !== 10'(f)) begin errors++; $display("[TB] FAIL scroll_frame%0d: got %0d expected %0d", f, ifB.VGA_R, f); end
    end
  endtask
`endif

  task automatic test_quadrant();
    ifC.MODE = 2'd0;
    ifC.SOLID_RGB = '0;
    resetC();
    stepC(5 * C_HT + 10);
    checks++;
    if ({ifC.VGA_R, ifC.VGA_G, ifC.VGA_B} !== {10'h0, 10'h0, 10'h050}) begin errors++; $display("[TB] FAIL quad_00: got %h expected B=050", {ifC.VGA_R, ifC.VGA_G, ifC.VGA_B}); end
    stepC(5 * C_HT + 70);
    checks++;
    if ({ifC.VGA_R, ifC.VGA_G, ifC.VGA_B} !== {10'h0, 10'h3FF, 10'h0}) begin errors++; $display("[TB] FAIL quad_10: got %h expected green", {ifC.VGA_R, ifC.VGA_G, ifC.VGA_B}); end
    stepC(70 * C_HT + 10);
    checks++;
    if ({ifC.VGA_R, ifC.VGA_G, ifC.VGA_B} !== {10'h3FF, 10'h0, 10'h0}) begin errors++; $display("[TB] FAIL quad_01: got %h expected red", {ifC.VGA_R, ifC.VGA_G, ifC.VGA_B}); end
    stepC(70 * C_HT + 70);
    checks++;
    if ({ifC.VGA_R, ifC.VGA_G, ifC.VGA_B} !== {10'h3FF, 10'h3FF, 10'h3FF}) begin errors++; $display("[TB] FAIL quad_11: got %h expected white", {ifC.VGA_R, ifC.VGA_G, ifC.VGA_B}); end
  endtask

  task automatic test_mode_change();
    ifC.MODE = 2'd0;
    ifC.SOLID_RGB = '0;
    resetC();
    stepC(10 * C_HT + 99);
    ifC.MODE = 2'd3;
    ifC.SOLID_RGB = {10'h200, 10'h100, 10'h080};
    stepC(20 * C_HT + 10);
    checks++;
    if ({ifC.VGA_R, ifC.VGA_G, ifC.VGA_B} !== {10'h0, 10'h0, 10'h140}) begin errors++; $display("[TB] FAIL change_same_frame_00: got %h expected B=140", {ifC.VGA_R, ifC.VGA_G, ifC.VGA_B}); end
    stepC(70 * C_HT + 70);
    checks++;
    if ({ifC.VGA_R, ifC.VGA_G, ifC.VGA_B} !== {10'h3FF, 10'h3FF, 10'h3FF}) begin errors++; $display("[TB] FAIL change_same_frame_11: got %h expected white", {ifC.VGA_R, ifC.VGA_G, ifC.VGA_B}); end
    stepC(C_FT);
    checks++;
    if (ifC.FRAME_START !== 1'b1) begin errors++; $display("[TB] FAIL change_next_fs: got %b expected 1", ifC.FRAME_START); end
    stepC(C_FT + 5 * C_HT + 10);
    checks++;
    if ({ifC.VGA_R, ifC.VGA_G, ifC.VGA_B} !== {10'h200, 10'h100, 10'h080}) begin errors++; $display("[TB] FAIL solid_next_frame_a: got %h expected 200/100/080", {ifC.VGA_R, ifC.VGA_G, ifC.VGA_B}); end
    stepC(C_FT + 70 * C_HT + 70);
    checks++;
    if ({ifC.VGA_R, ifC.VGA_G, ifC.VGA_B} !== {10'h200, 10'h100, 10'h080}) begin errors++; $display("[TB] FAIL solid_next_frame_b: got %h expected 200/100/080", {ifC.VGA_R, ifC.VGA_G, ifC.VGA_B}); end
    stepC(C_FT + 70 * C_HT + 130);
    checks++;
    if ({ifC.VGA_R, ifC.VGA_G, ifC.VGA_B} !== 30'h0 || ifC.VGA_BLANK !== 1'b0) begin errors++; $display("[TB] FAIL solid_blanked: got %h blank=%b expected 0 blank=0", {ifC.VGA_R, ifC.VGA_G, ifC.VGA_B}, ifC.VGA_BLANK); end
  endtask

  initial begin
    ifA.MODE = 2'd0; ifA.SOLID_RGB = '0;
    ifB.MODE = 2'd0; ifB.SOLID_RGB = '0;
    ifC.MODE = 2'd0; ifC.SOLID_RGB = '0;
    test_reset();
    test_line_timing();
    test_color_bars();
    test_reset_midframe();
    test_sync_polarity();
    test_grey_ramp();
`ifdef VGA_PATTERN_SCROLL_EN
    test_scroll();
`endif
    test_quadrant();
    test_mode_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
